// File: rtl/dmem_bytelane_if.sv
// dmem_bytelane_if: core-side request/response bus of the byte-lane data memory
interface dmem_bytelane_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wd;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rd;
  logic              fault;
  modport master(output req, we, funct3, addr, wd, input ready, rvalid, rd, fault);
  modport slave(input req, we, funct3, addr, wd, output ready, rvalid, rd, fault);
endinterface

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: RV32 byte-lane data memory, 1-cycle synchronous loads, fault detection.
module dmem_bytelane #(
  parameter int    DEPTH     = 2048,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE = ""
) (
  input logic            clk,
  input logic            reset,
  dmem_bytelane_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [AW-1:0]     idx;
  logic [1:0]        ofs;
  logic [2:0]        f3;
  logic              ready, sweep, accept, misaligned, illegal, bad;
  logic [AW-1:0]     sweep_idx;
  logic [31:0]       word, load_data, st_data, wr_data;
  logic [15:0]       lane;
  logic [3:0]        st_be, wr_be;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic              rvalid_d, rvalid_q, fault_d, fault_q;
  logic [31:0]       rd_d, rd_q;
  logic              unused_addr;
  assign addr        = bus.addr;
  assign idx         = addr[AW+1:2];
  assign ofs         = addr[1:0];
  assign f3          = bus.funct3;
  assign unused_addr = ^addr[ADDR_W-1:AW+2];
`ifdef DMEM_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t        state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = !reset && state_q == RUN;
    sweep     = !reset && state_q == CLEAR;
    sweep_idx = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == AW'(DEPTH - 1) ? RUN : CLEAR;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign ready     = !reset;
  assign sweep     = 1'b0;
  assign sweep_idx = '0;
`endif
  always_comb begin
    accept     = bus.req && ready;
    misaligned = (f3[1:0] == 2'b01 && ofs[0]) || (f3[1:0] == 2'b10 && ofs != 2'b00);
    illegal    = f3[1:0] == 2'b11 || f3 == 3'b110 || (f3[2] && bus.we);
    bad        = misaligned || illegal;
    word       = mem[idx];
    lane       = 16'(word >> {ofs, 3'b000});
    load_data  = f3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                 f3 == 3'b001 ? {{16{lane[15]}}, lane} :
                 f3 == 3'b100 ? {24'h0, lane[7:0]} :
                 f3 == 3'b101 ? {16'h0, lane} : word;
    st_be      = f3[1:0] == 2'b00 ? 4'b0001 << ofs :
                 f3[1:0] == 2'b01 ? (ofs[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_data    = f3[1:0] == 2'b00 ? {4{bus.wd[7:0]}} :
                 f3[1:0] == 2'b01 ? {2{bus.wd[15:0]}} : bus.wd;
    wr_en      = sweep || (accept && bus.we && !bad);
    wr_idx     = sweep ? sweep_idx : idx;
    wr_be      = sweep ? 4'hF : st_be;
    wr_data    = sweep ? '0 : st_data;
    rvalid_d   = accept && !bus.we;
    fault_d    = accept && bad;
    rd_d       = rvalid_d ? (bad ? '0 : load_data) : rd_q;
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      rd_q     <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      rd_q     <= rd_d;
    end
  end
  assign bus.ready  = ready;
  assign bus.rvalid = rvalid_q;
  assign bus.fault  = fault_q;
  assign bus.rd     = rd_q;
endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: scoreboard bench for dmem_bytelane at DEPTH=16, with or without DMEM_CLEAR_EN
module tb_dmem_bytelane;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  typedef struct {
    int          due;
    logic        ld;
    logic        flt;
    logic [31:0] rd;
    string       tag;
  } resp_t;
  resp_t      sb[$];
  logic [7:0] mb [64];
  dmem_bytelane_if #(.ADDR_W(32)) bus();
  dmem_bytelane #(.DEPTH(16), .ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rvalid || bus.fault) begin
      if (sb.size() == 0) chk("unexpected_response", {30'h0, bus.rvalid, bus.fault}, 32'h0);
      else begin
        resp_t e;
        e = sb.pop_front();
        chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
        chk({e.tag, "_rvalid"}, 32'(bus.rvalid), 32'(e.ld));
        chk({e.tag, "_fault"}, 32'(bus.fault), 32'(e.flt));
        if (e.ld) chk({e.tag, "_rd"}, bus.rd, e.rd);
      end
    end
  end
  task automatic access(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_f,
                        output int waited);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wd = d;
    waited = 0;
    @(negedge clk);
    while (!bus.ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    chk({tag, "_accept"}, 32'(bus.ready), 32'h1);
    if (bus.ready && (!w || exp_f)) sb.push_back('{cyc + 1, !w, exp_f, exp_rd, tag});
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask
  task automatic st(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                    input logic exp_f);
    int n;
    access(tag, 1'b1, f, a, d, 32'h0, exp_f, n);
  endtask
  task automatic ld(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp_rd,
                    input logic exp_f);
    int n;
    access(tag, 1'b0, f, a, 32'h0, exp_rd, exp_f, n);
  endtask
  task automatic do_reset();
    bus.req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 32'(bus.ready), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  function automatic logic [31:0] mload(input logic [2:0] f, input int a);
    int b;
    logic [31:0] w;
    b = a & 63;
    w = {mb[(b + 3) & 63], mb[(b + 2) & 63], mb[(b + 1) & 63], mb[b]};
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int          waited, a, b;
    logic [2:0]  f;
    logic        w;
    logic [31:0] v;
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b0; bus.addr = 32'h0; bus.wd = 32'h0;
    do_reset();
    @(negedge clk);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_rd", bus.rd, 32'h0);
`ifdef DMEM_CLEAR_EN
    chk("clear_ready0", 32'(bus.ready), 32'h0);
    @(posedge clk);
    #1;
    access("lw3c_clear", 1'b0, 3'b010, 32'h3C, 32'h0, 32'h0, 1'b0, waited);
    chk("clear_len", 32'(waited + 1), 32'd16);
`else
    chk("ready_after_reset", 32'(bus.ready), 32'h1);
    @(posedge clk);
    #1;
`endif
    st("sw08", 3'b010, 32'h08, 32'h800000F0, 1'b0);
    ld("lb08", 3'b000, 32'h08, 32'hFFFFFFF0, 1'b0);
    ld("lbu08", 3'b100, 32'h08, 32'h000000F0, 1'b0);
    ld("lh0a", 3'b001, 32'h0A, 32'hFFFF8000, 1'b0);
    ld("lhu0a", 3'b101, 32'h0A, 32'h00008000, 1'b0);
    ld("lb0b", 3'b000, 32'h0B, 32'hFFFFFF80, 1'b0);
    st("sw04", 3'b010, 32'h04, 32'h11223344, 1'b0);
    st("sb05", 3'b000, 32'h05, 32'h000000AB, 1'b0);
    st("sh06", 3'b001, 32'h06, 32'h0000BEEF, 1'b0);
    ld("lw04_merge", 3'b010, 32'h04, 32'hBEEFAB44, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rd_hold", bus.rd, 32'hBEEFAB44);
    st("sw00", 3'b010, 32'h00, 32'h01020304, 1'b0);
    st("sw04b", 3'b010, 32'h04, 32'h11223344, 1'b0);
    ld("lw04_pre", 3'b010, 32'h04, 32'h11223344, 1'b0);
    st("sw02_mis", 3'b010, 32'h02, 32'hDEADBEEF, 1'b1);
    ld("lw00_post", 3'b010, 32'h00, 32'h01020304, 1'b0);
    ld("lw04_post", 3'b010, 32'h04, 32'h11223344, 1'b0);
    ld("lh03_mis", 3'b001, 32'h03, 32'h0, 1'b1);
    ld("ld011_ill", 3'b011, 32'h00, 32'h0, 1'b1);
    ld("lhu01_mis", 3'b101, 32'h01, 32'h0, 1'b1);
    st("st100_ill", 3'b100, 32'h00, 32'h000000FF, 1'b1);
    st("st011_ill", 3'b011, 32'h00, 32'hFFFFFFFF, 1'b1);
    st("sh01_mis", 3'b001, 32'h01, 32'h0000FFFF, 1'b1);
    ld("lw00_intact", 3'b010, 32'h00, 32'h01020304, 1'b0);
    st("sw40_wrap", 3'b010, 32'h40, 32'hCAFEF00D, 1'b0);
    ld("lw00_wrap", 3'b010, 32'h00, 32'hCAFEF00D, 1'b0);
    ld("lwc0_alias", 3'b010, 32'hFFFFFFC0, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      st("rnd_init", 3'b010, 32'(4 * i), v, 1'b0);
      for (int k = 0; k < 4; k++) mb[4 * i + k] = v[8 * k +: 8];
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       f = 3'b000;
        1:       f = 3'b001;
        2:       f = 3'b010;
        3:       f = 3'b100;
        default: f = 3'b101;
      endcase
      w = f[2] ? 1'b0 : 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, 255));
      if (f[1:0] == 2'b01) a = a & ~1;
      if (f[1:0] == 2'b10) a = a & ~3;
      v = $urandom;
      if (w) begin
        st("rnd_st", f, 32'(a), v, 1'b0);
        b = a & 63;
        mb[b] = v[7:0];
        if (f[1:0] != 2'b00) mb[b + 1] = v[15:8];
        if (f[1:0] == 2'b10) begin
          mb[b + 2] = v[23:16];
          mb[b + 3] = v[31:24];
        end
      end else ld("rnd_ld", f, 32'(a), mload(f, a), 1'b0);
    end
`ifdef DMEM_CLEAR_EN
    do_reset();
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    access("lw08_resweep", 1'b0, 3'b010, 32'h08, 32'h0, 32'h0, 1'b0, waited);
    chk("resweep_len", 32'(waited), 32'd16);
`endif
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
